// File: rtl/riscv_pkg.sv
// Shared types and register-map constants for the memory-mapped UART transmitter.
// MMIO_UART_PARITY_EN moves the STATUS count field up one bit to make room for the parity flag.
package riscv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int UART_TXDATA_OFS   = 0;
    localparam int UART_STATUS_OFS   = 4;
    localparam int UART_WINDOW_BYTES = 8;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_EMPTY_BIT = 2;
    localparam int STAT_OVF_BIT   = 3;
`ifdef MMIO_UART_PARITY_EN
    localparam int STAT_PAR_BIT   = 4;
    localparam int STAT_CNT_LSB   = 5;
`else
    localparam int STAT_CNT_LSB   = 4;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes while full and pops while empty are ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores feed a TX FIFO drained by a baud-timed FSM.
// Define MMIO_UART_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx
    import riscv_pkg::*;
#(
    parameter int          ALEN         = 32,
    parameter int          XLEN         = 32,
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ALEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_we,
    input  logic [3:0]      dmem_be,
    output logic            sel,
    output logic [XLEN-1:0] rdata,
    output logic            tx,
    output logic            busy
);

    // state  | meaning
    // IDLE   | line high, waiting for a byte in the FIFO
    // START  | start bit (low)
    // DATA   | eight data bits, LSB first
    // PARITY | even parity of the byte (parity build only)
    // STOP   | stop bit (high); pops the next byte at its end if one is waiting

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    logic [ALEN-1:0]  offset;
    logic [2:0]       reg_ofs;
    logic             is_txdata;
    logic             is_status;
    logic             wr_txdata;
    logic             wr_status;
    logic [XLEN-1:0]  status;
    logic             ovf;

    logic             fifo_pop;
    logic [7:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    uart_state_t      state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             baud_tc;
    logic             fsm_busy;
`ifdef MMIO_UART_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             unused_bits;
    assign unused_bits = ^{dmem_wdata, dmem_be[3:1]};

    // Subtracting the base lets a single unsigned compare reject addresses on both sides of the window.
    assign offset    = dmem_addr - ALEN'(BASE_ADDR);
    assign sel       = (offset < ALEN'(UART_WINDOW_BYTES));
    assign reg_ofs   = {offset[2], 2'b00};
    assign is_txdata = (reg_ofs == 3'(UART_TXDATA_OFS));
    assign is_status = (reg_ofs == 3'(UART_STATUS_OFS));
    assign wr_txdata = sel && dmem_we && dmem_be[0] && is_txdata;
    assign wr_status = sel && dmem_we && dmem_be[0] && is_status;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst),
        .push  (wr_txdata),
        .wdata (dmem_wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (wr_status && dmem_wdata[STAT_OVF_BIT]) begin
            ovf <= 1'b0;
        end else if (wr_txdata && fifo_full) begin
            ovf <= 1'b1;
        end
    end

    always_comb begin
        status                 = '0;
        status[STAT_BUSY_BIT]  = fsm_busy;
        status[STAT_FULL_BIT]  = fifo_full;
        status[STAT_EMPTY_BIT] = fifo_empty;
        status[STAT_OVF_BIT]   = ovf;
`ifdef MMIO_UART_PARITY_EN
        status[STAT_PAR_BIT]   = 1'b1;
`endif
        status[STAT_CNT_LSB +: CNT_W] = fifo_count;
    end

    assign rdata    = (sel && is_status) ? status : '0;
    assign fsm_busy = (state_q != IDLE);
    assign busy     = fsm_busy || !fifo_empty;
    assign baud_tc  = (baud_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef MMIO_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef MMIO_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
`ifdef MMIO_UART_PARITY_EN
        par_d    = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    baud_d   = BAUD_LOAD;
                    state_d  = START;
`ifdef MMIO_UART_PARITY_EN
                    par_d    = ^fifo_rdata;
`endif
                end
            end
            START: begin
                baud_d = baud_q - BAUD_ONE;
                if (baud_tc) begin
                    baud_d  = BAUD_LOAD;
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                baud_d = baud_q - BAUD_ONE;
                if (baud_tc) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef MMIO_UART_PARITY_EN
            PARITY: begin
                baud_d = baud_q - BAUD_ONE;
                if (baud_tc) begin
                    baud_d  = BAUD_LOAD;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                baud_d = baud_q - BAUD_ONE;
                if (baud_tc) begin
                    // Chain straight into the next start bit so queued bytes leave with no idle gap.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        baud_d   = BAUD_LOAD;
                        state_d  = START;
`ifdef MMIO_UART_PARITY_EN
                        par_d    = ^fifo_rdata;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
`ifdef MMIO_UART_PARITY_EN
            PARITY:  tx = par_q;
`endif
            default: tx = 1'b1;
        endcase
    end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data-memory port, downstream of the MEM stage.
- Consumes the core's dmem address, write data, write enable and byte enables, and returns read data combinationally in the same cycle.
- CPU stores push bytes into a TX FIFO. A baud-timed FSM serialises them 8N1, LSB first, on the tx pin.

Parameters:
- ALEN, 32, address width (matches core dmem_addr).
- XLEN, 32, data width (matches core dmem_wdata/dmem_rdata).
- BASE_ADDR, 32'h1000_0000, base of the 8-byte register window.
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal values >= 2.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- dmem_addr  in  ALEN  byte address from MEM stage
- dmem_wdata  in  XLEN  store data
- dmem_we  in  1  store strobe, one cycle per store
- dmem_be  in  4  byte enables of the store
- sel  out  1  address falls in [BASE_ADDR, BASE_ADDR+7]
- rdata  out  XLEN  register read data, combinational
- tx  out  1  serial output, idle high
- busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Register map, word-aligned; dmem_addr[1:0] ignored:
  - +0 TXDATA: write pushes wdata[7:0] when be[0]=1; reads 0.
  - +4 STATUS: read {count[XLEN-5:0 slice as needed], ovf, empty, full, fsm_busy} in bits [..4], 3, 2, 1, 0.
  - +4 STATUS write with wdata[3]=1 and be[0]=1 clears ovf; other bits read-only.
- rdata = 0 when sel=0. Reads have no side effects.
- Reset, asynchronous and active-low:
  - FIFO empty, pointers 0, ovf=0, FSM IDLE, baud counter 0.
  - Outputs: tx=1, busy=0, rdata derives from reset state (STATUS = 0x4).
  - Reset mid-frame aborts the frame; tx returns high immediately.
- Push:
  - A push attempted while count==FIFO_DEPTH is dropped and sets sticky ovf.
  - The full check uses the pre-cycle count, even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO leaves count unchanged.
- FSM states IDLE, START, DATA, STOP. Each non-IDLE state lasts exactly CLKS_PER_BIT cycles, timed by a down-counter.
  - IDLE: when the FIFO is non-empty, pop into an 8-bit shift register and enter START. tx goes low the cycle after the pop.
  - Latency is 2 cycles from the TXDATA store cycle to the tx falling edge when idle and empty.
  - START: tx=0. DATA: tx=shift[0]; shift right after each bit; a 3-bit counter counts 8 bits. STOP: tx=1.
  - At the end of STOP: if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles.
- Width rules:
  - Pointers are log2(FIFO_DEPTH) bits and wrap modulo depth.
  - count is log2(FIFO_DEPTH)+1 bits, range 0..FIFO_DEPTH.
- Out-of-window and unaligned-window writes are ignored.

Optional Feature:
- Macro MMIO_UART_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP, lasting CLKS_PER_BIT cycles, with tx = ^data (even parity).
  - Frame becomes 11*CLKS_PER_BIT.
  - STATUS bit 4 reads 1 (parity-present flag); count shifts to bits [..5].
- Undefined: no PARITY state and STATUS bit 4 reads count[0], as above.

Decomposition:
- Package riscv_pkg gains:
  - uart_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - localparams UART_TXDATA_OFS=0, UART_STATUS_OFS=4.
  - STATUS bit-index constants.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty/count), reusable elsewhere. The FSM, baud counter and register decode stay in mmio_uart_tx.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> tx=1, busy=0, read STATUS=0x4. Assert rst low mid-DATA -> tx=1 in the same cycle.
- Single byte, CLKS_PER_BIT=4: store 0x55 to +0 -> tx low at cycle +2, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, stop high, busy falls at cycle +42.
- Back-to-back: store 0xA5 then 0x3C on consecutive cycles -> two frames with no idle gap, second start bit immediately after the first stop; decoded bytes 0xA5, 0x3C.
- Overflow, FIFO_DEPTH=8, CLKS_PER_BIT=4:
  - 10 stores in consecutive cycles -> full=1, ovf=1; bytes 1-9 transmitted, byte 10 lost.
  - Write STATUS 0x8 -> ovf=0.
- Decode: stores to BASE+8 and BASE-4 -> sel=0, no push, rdata=0. Store to +0 with be=4'b0010 -> no push.
- Parity (MMIO_UART_PARITY_EN defined): store 0x07 -> parity bit 1 after data, frame length 44 cycles; STATUS bit 4 = 1.
